sram_march_checker: RTL

Self-checking external SRAM tester for the CW310 board-test image, sitting between the register block's `sram_en`/`top_address` outputs and the SRAM pins. On request it writes an address-derived pattern over a programmable region, reads it back, then repeats with the inverted pattern. It reports pass/fail back to the register block, together with the first failing address and data. It replaces the minimal read/write check with a fully deterministic, cycle-exact sequencer.

---
 rtl/sram_march_checker_if.sv | 32 +++
 rtl/sram_march_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_checker_if.sv
// Register-block and SRAM control/address signals of the march checker.
// The bidirectional data bus stays a plain inout port on the checker itself.
interface sram_march_checker_if #(
   parameter int pDATA_WIDTH = 8,
   parameter int pADDR_WIDTH = 21
);
   logic                   active;
   logic [7:0]             I_top_address;
   logic                   busy;
   logic                   pass;
   logic                   fail;
   logic [pADDR_WIDTH-1:0] fail_addr;
   logic [pDATA_WIDTH-1:0] fail_expected;
   logic [pDATA_WIDTH-1:0] fail_actual;
   logic                   wen;
   logic                   oen;
   logic                   cen;
   logic                   ce2;
   logic [pADDR_WIDTH-1:0] addr;

   modport master (
      output active, I_top_address,
      input  busy, pass, fail, fail_addr, fail_expected, fail_actual,
      input  wen, oen, cen, ce2, addr
   );

   modport slave (
      input  active, I_top_address,
      output busy, pass, fail, fail_addr, fail_expected, fail_actual,
      output wen, oen, cen, ce2, addr
   );
endinterface

// File: rtl/sram_march_checker.sv
// External SRAM march tester: writes pat(a), reads it back, then repeats with ~pat(a)
// over 0..E, recording the first mismatch. All pin-facing outputs are registered.
module sram_march_checker #(
   parameter int pDATA_WIDTH  = 8,
   parameter int pADDR_WIDTH  = 21,
   parameter int pWAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   sram_march_checker_if.slave    bus,
   inout  wire  [pDATA_WIDTH-1:0] data
);
   localparam int NCHUNK = (pADDR_WIDTH + pDATA_WIDTH - 1) / pDATA_WIDTH;
   localparam int CW     = $clog2(pWAIT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_CAP  = CW'(pWAIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(pWAIT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_TURN = 3'd1,
      S_WR0  = 3'd2,
      S_RD0  = 3'd3,
      S_WR1  = 3'd4,
      S_RD1  = 3'd5,
      S_DONE = 3'd6
   } state_t;

   // XOR-fold of the address into data-width chunks, top chunk zero-extended.
   function automatic logic [pDATA_WIDTH-1:0] pat(input logic [pADDR_WIDTH-1:0] a);
      logic [NCHUNK*pDATA_WIDTH-1:0] ext;
      logic [pDATA_WIDTH-1:0]        acc;
      ext                    = '0;
      ext[pADDR_WIDTH-1:0]   = a;
      acc                    = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         acc = acc ^ ext[i*pDATA_WIDTH +: pDATA_WIDTH];
      end
      return acc;
   endfunction

   state_t                 state_q;
   logic [1:0]             phase_q;
   logic [CW-1:0]          cnt_q;
   logic [pADDR_WIDTH-1:0] addr_q;
   logic [pADDR_WIDTH-1:0] end_q;
   logic [pDATA_WIDTH-1:0] dout_q;
   logic                   doe_q;
   logic [pDATA_WIDTH-1:0] rdata_q;
   logic                   wen_q, oen_q, cen_q, ce2_q;
   logic                   busy_q, pass_q, fail_q;
   logic [pADDR_WIDTH-1:0] fail_addr_q;
   logic [pDATA_WIDTH-1:0] fail_exp_q, fail_act_q;

   logic                   is_wr_d;
   logic [pDATA_WIDTH-1:0] inv_d;
   logic [pDATA_WIDTH-1:0] exp_d;
   logic [pADDR_WIDTH-1:0] addr_nx_d;
   logic [pDATA_WIDTH-1:0] wdat_nx_d;
   logic [pADDR_WIDTH-1:0] end_d;
   state_t                 turn_nx_d;

   // Compare value, next write value and next access state from address and phase.
   always_comb begin
      is_wr_d   = (state_q == S_WR0) || (state_q == S_WR1);
      inv_d     = {pDATA_WIDTH{phase_q[1]}};
      exp_d     = pat(addr_q) ^ inv_d;
      addr_nx_d = addr_q + pADDR_WIDTH'(1);
      wdat_nx_d = pat(addr_nx_d) ^ inv_d;
      end_d     = {bus.I_top_address, {(pADDR_WIDTH-8){1'b1}}};
      case (phase_q)
         2'd0:    turn_nx_d = S_WR0;
         2'd1:    turn_nx_d = S_RD0;
         2'd2:    turn_nx_d = S_WR1;
         default: turn_nx_d = S_RD1;
      endcase
   end

   // Test sequencer with registered strobes, bus enable and result flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         phase_q     <= 2'd0;
         cnt_q       <= '0;
         addr_q      <= '0;
         end_q       <= '0;
         dout_q      <= '0;
         doe_q       <= 1'b0;
         rdata_q     <= '0;
         wen_q       <= 1'b1;
         oen_q       <= 1'b1;
         cen_q       <= 1'b1;
         ce2_q       <= 1'b0;
         busy_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_exp_q  <= '0;
         fail_act_q  <= '0;
      end else if ((state_q != S_IDLE) && !bus.active) begin
         // Abort: results cleared, strobes and bus released, fail_* kept for inspection.
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         doe_q   <= 1'b0;
         wen_q   <= 1'b1;
         oen_q   <= 1'b1;
         cen_q   <= 1'b1;
         ce2_q   <= 1'b0;
         busy_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.active && !pass_q && !fail_q) begin
                  state_q     <= S_TURN;
                  phase_q     <= 2'd0;
                  end_q       <= end_d;
                  busy_q      <= 1'b1;
                  fail_addr_q <= '0;
                  fail_exp_q  <= '0;
                  fail_act_q  <= '0;
               end
            end
            S_TURN: begin
               state_q <= turn_nx_d;
               addr_q  <= '0;
               cnt_q   <= '0;
               cen_q   <= 1'b0;
               ce2_q   <= 1'b1;
               wen_q   <= phase_q[0];
               oen_q   <= ~phase_q[0];
               doe_q   <= ~phase_q[0];
               dout_q  <= inv_d;
            end
            S_WR0, S_RD0, S_WR1, S_RD1: begin
               if (cnt_q != CNT_LAST) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == CNT_CAP) begin
                     wen_q <= 1'b1;
                     oen_q <= 1'b1;
                     if (!is_wr_d) begin
                        rdata_q <= data;
                     end
                  end
               end else if (!is_wr_d && (rdata_q != exp_d)) begin
                  state_q     <= S_DONE;
                  fail_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  fail_addr_q <= addr_q;
                  fail_exp_q  <= exp_d;
                  fail_act_q  <= rdata_q;
                  cen_q       <= 1'b1;
                  ce2_q       <= 1'b0;
                  doe_q       <= 1'b0;
               end else if (addr_q == end_q) begin
                  cen_q <= 1'b1;
                  ce2_q <= 1'b0;
                  doe_q <= 1'b0;
                  cnt_q <= '0;
                  if (phase_q == 2'd3) begin
                     state_q <= S_DONE;
                     pass_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_TURN;
                     phase_q <= phase_q + 2'd1;
                  end
               end else begin
                  addr_q <= addr_nx_d;
                  cnt_q  <= '0;
                  wen_q  <= ~is_wr_d;
                  oen_q  <= is_wr_d;
                  dout_q <= wdat_nx_d;
               end
            end
            S_DONE: begin
               cen_q <= 1'b1;
               ce2_q <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy          = busy_q;
   assign bus.pass          = pass_q;
   assign bus.fail          = fail_q;
   assign bus.fail_addr     = fail_addr_q;
   assign bus.fail_expected = fail_exp_q;
   assign bus.fail_actual   = fail_act_q;
   assign bus.wen           = wen_q;
   assign bus.oen           = oen_q;
   assign bus.cen           = cen_q;
   assign bus.ce2           = ce2_q;
   assign bus.addr          = addr_q;
   assign data              = doe_q ? dout_q : {pDATA_WIDTH{1'bz}};
endmodule
